// File: rtl/trap_ctrl_if.sv
// Trap CSR channel between the trap sequencer and the CSR file.
// The sequencer drives one CSR access per cycle. The CSR file returns read data
// combinationally for whatever address is currently presented.
interface trap_ctrl_if;
  logic        trap_csr_we_o;
  logic [11:0] trap_csr_addr_o;
  logic [31:0] trap_csr_wdata_o;
  logic [31:0] trap_csr_rdata_i;

  // Trap sequencer side
  modport master (
    output trap_csr_we_o,
    output trap_csr_addr_o,
    output trap_csr_wdata_o,
    input  trap_csr_rdata_i
  );

  // CSR file side
  modport slave (
    input  trap_csr_we_o,
    input  trap_csr_addr_o,
    input  trap_csr_wdata_o,
    output trap_csr_rdata_i
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer between execute/writeback and the CSR file.
// On trap entry it saves mepc, mcause, mtval and mstatus, one CSR per cycle,
// and then redirects to mtvec. On mret it restores mstatus and redirects to mepc.
//
// state      | meaning
// -----------+------------------------------------------------
// IDLE       | waiting for an instruction boundary with a trap or mret
// W_MEPC     | write saved epc to mepc
// W_MCAUSE   | write latched cause to mcause
// W_MTVAL    | write latched tval to mtval
// W_MSTATUS  | mstatus: MPIE <= MIE, MIE <= 0
// T_JUMP     | read mtvec and redirect to the handler
// R_MSTATUS  | mstatus: MIE <= MPIE, MPIE <= 1
// R_JUMP     | redirect to mepc
module trap_ctrl #(
  parameter logic [31:0] CAUSE_ECALL   = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK  = 32'd3,
  parameter logic [31:0] CAUSE_ILLEGAL = 32'd2,
  parameter logic [31:0] CAUSE_MEI     = 32'h8000000B,
  parameter logic [31:0] CAUSE_MSI     = 32'h80000003,
  parameter logic [31:0] CAUSE_MTI     = 32'h80000007
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hx_valid,
  input  logic [31:0]       inst_pc_i,
  input  logic [31:0]       next_pc_i,
  input  logic [31:0]       inst_i,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              illegal_i,
  input  logic              mret_i,
  input  logic              ex_trap_valid_i,
  input  logic              soft_trap_valid_i,
  input  logic              tcmp_trap_valid_i,
  input  logic              mstatus_MIE3_i,
  input  logic [31:0]       mepc_i,
  trap_ctrl_if.master       csr,
  output logic              hold_o,
  output logic              jump_o,
  output logic [31:0]       jump_addr_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MTVAL   = 3'd3,
    W_MSTATUS = 3'd4,
    T_JUMP    = 3'd5,
    R_MSTATUS = 3'd6,
    R_JUMP    = 3'd7
  } state_t;

  state_t      state, state_nxt;

  logic [31:0] cause_q, epc_q, tval_q;
  logic [31:0] cause_d, epc_d, tval_d;

  logic        exc_hit;
  logic        irq_hit;
  logic        trap_hit;
  logic        mret_hit;

  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] rdata;

  assign rdata = csr.trap_csr_rdata_i;

  // Entry qualification. Exceptions win over mret, and mret wins over interrupts.
  always_comb begin
    exc_hit  = hx_valid & (illegal_i | ebreak_i | ecall_i);
    mret_hit = hx_valid & mret_i & ~exc_hit;
    irq_hit  = hx_valid & mstatus_MIE3_i & ~mret_i &
               (ex_trap_valid_i | soft_trap_valid_i | tcmp_trap_valid_i);
    trap_hit = exc_hit | irq_hit;
  end

  // Cause, epc and tval selected for the trap being taken this cycle
  always_comb begin
    cause_d = 32'd0;
    epc_d   = 32'd0;
    tval_d  = 32'd0;
    if (exc_hit) begin
      epc_d = inst_pc_i;
      if (illegal_i) begin
        cause_d = CAUSE_ILLEGAL;
        tval_d  = inst_i;
      end else if (ebreak_i) begin
        cause_d = CAUSE_EBREAK;
        tval_d  = inst_pc_i;
      end else begin
        cause_d = CAUSE_ECALL;
      end
    end else begin
      // An interrupt is taken on the boundary, so the return address is the next PC
      epc_d = next_pc_i;
      if (ex_trap_valid_i)        cause_d = CAUSE_MEI;
      else if (soft_trap_valid_i) cause_d = CAUSE_MSI;
      else                        cause_d = CAUSE_MTI;
    end
  end

  // Latch trap info on entry. It stays stable while the sequence runs,
  // even if the request drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q <= 32'd0;
      epc_q   <= 32'd0;
      tval_q  <= 32'd0;
    end else if (state == IDLE && trap_hit) begin
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (trap_hit)      state_nxt = W_MEPC;
        else if (mret_hit) state_nxt = R_MSTATUS;
      end
      W_MEPC:    state_nxt = W_MCAUSE;
      W_MCAUSE:  state_nxt = W_MTVAL;
      W_MTVAL:   state_nxt = W_MSTATUS;
      W_MSTATUS: state_nxt = T_JUMP;
      T_JUMP:    state_nxt = IDLE;
      R_MSTATUS: state_nxt = R_JUMP;
      R_JUMP:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode: the CSR access, hold and redirect for each state
  always_comb begin
    csr_we      = 1'b0;
    csr_addr    = 12'h000;
    csr_wdata   = 32'd0;
    hold_o      = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = 32'd0;
    case (state)
      IDLE: begin
        // Stall from the detect cycle, so idex cannot race the sequence to the CSRs
        hold_o = (trap_hit | mret_hit) & ~rst;
      end
      W_MEPC: begin
        hold_o    = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = ADDR_MEPC;
        csr_wdata = epc_q;
      end
      W_MCAUSE: begin
        hold_o    = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = ADDR_MCAUSE;
        csr_wdata = cause_q;
      end
      W_MTVAL: begin
        hold_o    = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = ADDR_MTVAL;
        csr_wdata = tval_q;
      end
      W_MSTATUS: begin
        hold_o       = 1'b1;
        csr_we       = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_wdata    = rdata;
        csr_wdata[7] = rdata[3];
        csr_wdata[3] = 1'b0;
      end
      T_JUMP: begin
        // mtvec low bits carry the mode field. The handler base is word aligned.
        hold_o      = 1'b1;
        csr_addr    = ADDR_MTVEC;
        jump_o      = 1'b1;
        jump_addr_o = {rdata[31:2], 2'b00};
      end
      R_MSTATUS: begin
        hold_o       = 1'b1;
        csr_we       = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_wdata    = rdata;
        csr_wdata[3] = rdata[7];
        csr_wdata[7] = 1'b1;
      end
      R_JUMP: begin
        hold_o      = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = mepc_i;
      end
      default: ;
    endcase
  end

  assign csr.trap_csr_we_o    = csr_we;
  assign csr.trap_csr_addr_o  = csr_addr;
  assign csr.trap_csr_wdata_o = csr_wdata;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer between the execute/writeback stage and the CSR file.
- Consumes the masked interrupt requests and global MIE from the CSR file, plus synchronous exception and mret flags from idex.
- Drives the CSR file's trap read/write channel one CSR per cycle to save and restore trap state.
- Holds the pipeline during each sequence and issues a single-cycle redirect to the handler (mtvec) or return address (mepc).

Parameters:
- CAUSE_ECALL, 32'd11, mcause value for ecall.
- CAUSE_EBREAK, 32'd3, mcause value for ebreak.
- CAUSE_ILLEGAL, 32'd2, mcause value for illegal instruction.
- CAUSE_MEI / CAUSE_MSI / CAUSE_MTI, 32'h8000000B / 32'h80000003 / 32'h80000007, interrupt mcause values.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- hx_valid  in  1  instruction retiring this cycle (instruction boundary)
- inst_pc_i  in  32  PC of the retiring instruction
- next_pc_i  in  32  PC the retiring instruction would continue to
- inst_i  in  32  retiring instruction word (source of mtval for illegal)
- ecall_i / ebreak_i / illegal_i / mret_i  in  1 each  qualified by hx_valid
- ex_trap_valid_i / soft_trap_valid_i / tcmp_trap_valid_i  in  1 each  masked requests from CSR file
- mstatus_MIE3_i  in  1  global interrupt enable
- mepc_i  in  32  direct mepc value from CSR file
- trap_csr_we_o  out  1  CSR write enable
- trap_csr_addr_o  out  12  CSR address
- trap_csr_wdata_o  out  32  CSR write data
- trap_csr_rdata_i  in  32  CSR read data; combinational from trap_csr_addr_o, same cycle
- hold_o  out  1  stall fetch/idex; idex must not issue CSR writes while high
- jump_o  out  1  one-cycle redirect strobe
- jump_addr_o  out  32  redirect target

Behaviour:
- Reset: state IDLE; all outputs and latched registers (cause, epc, tval) = 0.
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, T_JUMP, R_MSTATUS, R_JUMP.
- Trap entry, evaluated in IDLE only, when hx_valid=1:
  - Exception priority: illegal > ebreak > ecall.
  - Exceptions beat interrupts.
  - Interrupts need mstatus_MIE3_i=1; priority MEI > MSI > MTI.
  - On entry, latch cause.
  - Latch epc = inst_pc_i for exceptions, next_pc_i for interrupts.
  - Latch tval = inst_i for illegal, inst_pc_i for ebreak, 0 otherwise.
  - Go to W_MEPC.
- Each write state asserts we=1 with a fixed address; wdata per state:
  - W_MEPC: addr 0x341, wdata epc.
  - W_MCAUSE: addr 0x342, wdata cause.
  - W_MTVAL: addr 0x343, wdata tval.
  - W_MSTATUS: addr 0x300; wdata = trap_csr_rdata_i with bit7 := rdata[3] and bit3 := 0.
- T_JUMP: we=0, addr 0x305; jump_o=1, jump_addr_o={trap_csr_rdata_i[31:2],2'b00}; go to IDLE.
- mret (IDLE, hx_valid, no exception flag set) goes to R_MSTATUS, which writes 0x300 with wdata = rdata, bit3 := rdata[7], bit7 := 1.
- R_JUMP: jump_o=1, jump_addr_o=mepc_i; go to IDLE.
- mret beats pending interrupts. An interrupt still pending is re-evaluated at the next hx_valid in IDLE.
- hold_o: combinational. High in the IDLE cycle where entry is detected and in every non-IDLE state through the jump cycle.
- Latency:
  - trap: detect cycle, then 4 write cycles, then jump (jump_o 5 cycles after detect);
  - mret: jump_o 2 cycles after detect.
- Outside IDLE:
  - all request inputs are ignored;
  - interrupt deassertion mid-sequence does not abort; latched cause is used.
- In IDLE: we=0, addr=0, wdata=0, jump_o=0.
- rst asserted mid-sequence: immediate return to IDLE with outputs 0; partial CSR writes are not undone.
- jump_o is high for exactly one cycle per sequence.

Test Plan:
- Reset, then ecall at inst_pc_i=0x100, mtvec=0x2003, mstatus=0x8 -> writes 0x341=0x100, 0x342=11, 0x343=0, 0x300 bit7=1/bit3=0; jump_o at cycle 5 with addr 0x2000; hold_o high 6 cycles.
- tcmp_trap_valid_i=1, MIE=1, hx_valid, next_pc_i=0x204 -> mepc=0x204, mcause=0x80000007, mtval=0.
- ex, soft and tcmp requests plus illegal_i in the same cycle (inst_i=0xFFFFFFFF) -> mcause=2, mtval=0xFFFFFFFF. With no exception, the same three requests -> mcause=0x8000000B.
- MIE=0 with ex_trap_valid_i=1 -> no hold, no writes; then mret_i with mstatus=0x80, mepc_i=0x300 -> mstatus write 0x88, jump to 0x300 two cycles later.
- ex_trap_valid_i pulses one cycle during W_MEPC of an ecall trap -> ignored; mcause=11.
- rst asserted during W_MTVAL -> next cycle IDLE, we=0, hold_o=0, jump_o never asserted.
